// File: rtl/module_bcd_display_scan_pkg.sv
// rtl/module_bcd_display_scan_pkg.sv - segment lookup constants and BCD digit type for the display scanner
package pkg_display;

   typedef logic [3:0] bcd_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_PATTERN [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/module_bcd_display_scan_if.sv
// rtl/module_bcd_display_scan_if.sv - load/value/pending bundle between keypad capture and display scanner
interface module_bcd_display_scan_if #(
   parameter int N_DIGITS = 2
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   val_in;
   logic                    pending;

   modport master (output load, output val_in, input pending);
   modport slave  (input load, input val_in, output pending);
endinterface

// File: rtl/module_bcd_display_scan_bcd_to_7seg.sv
// rtl/module_bcd_display_scan_bcd_to_7seg.sv - combinational BCD digit to active-low 7-segment decode
module bcd_to_7seg
   import pkg_display::*;
(
   input  bcd_t        bcd,
   output logic [6:0]  seg
);

   // Non-decimal nibbles show a dash rather than garbage
   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9) seg = SEG_PATTERN[bcd];
   end

endmodule

// File: rtl/module_bcd_display_scan.sv
// rtl/module_bcd_display_scan.sv - double-buffered multiplexed 7-segment scanner (optional LEADING_ZERO_BLANK_EN)
module module_bcd_display_scan
   import pkg_display::*;
#(
   parameter int N_DIGITS    = 2,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   module_bcd_display_scan_if.slave bus,
   output logic [N_DIGITS-1:0]    an,
   output logic [6:0]             seg,
   output logic                   frame_start
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*N_DIGITS-1:0]   shadow;
   logic [4*N_DIGITS-1:0]   disp;
   logic                    pending_q;

   logic                    tc;
   logic                    boundary;
   bcd_t                    cur_digit;
   logic [6:0]              seg_dec;
   logic                    blank;
   logic [N_DIGITS-1:0]     an_next;

   assign tc       = (cnt == CNT_LAST);
   assign boundary = tc && (idx == IDX_LAST);
   assign bus.pending = pending_q;

   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IW'(i)) cur_digit = disp[4*i +: 4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [N_DIGITS-1:0] upper_zero;

   // upper_zero[k]: digits k..N_DIGITS-1 of disp are all zero
   always_comb begin
      upper_zero = '0;
      upper_zero[N_DIGITS-1] = (disp[4*(N_DIGITS-1) +: 4] == 4'd0);
      for (int k = N_DIGITS - 2; k >= 0; k--) begin
         upper_zero[k] = upper_zero[k+1] && (disp[4*k +: 4] == 4'd0);
      end
      blank = 1'b0;
      for (int k = 1; k < N_DIGITS; k++) begin
         if (idx == IW'(k) && upper_zero[k]) blank = 1'b1;
      end
   end
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      an_next = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx == IW'(i) && !blank) an_next[i] = 1'b0;
      end
   end

   bcd_to_7seg u_dec (
      .bcd (cur_digit),
      .seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         idx         <= '0;
         shadow      <= '0;
         disp        <= '0;
         pending_q   <= 1'b0;
         frame_start <= 1'b0;
         an          <= '1;
         seg         <= SEG_OFF;
      end else begin
         if (tc) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
         end else begin
            cnt <= cnt + CW'(1);
         end

         frame_start <= boundary;
         // disp takes the pre-edge shadow, so a load on the boundary waits a frame
         if (boundary) disp <= shadow;

         if (bus.load) begin
            shadow    <= bus.val_in;
            pending_q <= 1'b1;
         end else if (boundary) begin
            pending_q <= 1'b0;
         end

         an  <= an_next;
         seg <= blank ? SEG_OFF : seg_dec;
      end
   end

endmodule
